// File: rtl/fir_coeff_loader.sv
// Purpose : streams N signed coefficients into the FIR top's SRAM update port
//           (update flag, active-low CS/WE, linear address, write data).
// Latency : beat accepted at edge t is strobed in cycle t+1; start->oDone = N+GUARD_CYCLES+2.
// Backpressure: oCoeffReady is high only in WRITE; stalls are unbounded, no timeout.
// Ports:
//   iClk12M, iRsn            clock, synchronous active-low reset
//   iStart, iNumOfCoeff      load request and tap count (sampled together in IDLE)
//   iAbort                   cancels a load in SETUP/WRITE/GUARD
//   iCoeffValid/Data, oCoeffReady   coefficient stream (valid/ready)
//   oCoeffUpdateFlag, oCsnRam, oWrnRam, oAddrRam, oWrDtRam   SRAM write port to FIR top
//   oNumOfCoeff              latched tap count
//   oBusy, oDone, oErr       status (oDone/oErr are 1-cycle pulses)
module fir_coeff_loader #(
  parameter int MAX_COEFF    = 40,
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  iClk12M,
  input  logic                  iRsn,
  input  logic                  iStart,
  input  logic                  iAbort,
  input  logic [ADDR_WIDTH-1:0] iNumOfCoeff,
  input  logic                  iCoeffValid,
  input  logic [DATA_WIDTH-1:0] iCoeffData,
  output logic                  oCoeffReady,
  output logic                  oCoeffUpdateFlag,
  output logic                  oCsnRam,
  output logic                  oWrnRam,
  output logic [ADDR_WIDTH-1:0] oAddrRam,
  output logic [DATA_WIDTH-1:0] oWrDtRam,
  output logic [ADDR_WIDTH-1:0] oNumOfCoeff,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    GUARD = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT                 state;
  stateT                 nextState;
  logic [ADDR_WIDTH-1:0] idx;
  logic [GW-1:0]         guardCnt;

  logic countOk;
  logic startOk;
  logic startBad;
  logic abortHit;
  logic accept;
  logic lastBeat;
  logic guardEnd;

  // Next values of the registered outputs, produced by the output process.
  logic flagNxt;
  logic strobeNxt;
  logic busyNxt;
  logic doneNxt;
  logic errNxt;

  assign countOk  = (iNumOfCoeff != '0) && (iNumOfCoeff <= ADDR_WIDTH'(MAX_COEFF));
  assign startOk  = (state == IDLE) && iStart && countOk;
  assign startBad = (state == IDLE) && iStart && !countOk;
  assign abortHit = iAbort && ((state == SETUP) || (state == WRITE) || (state == GUARD));
  assign accept   = (state == WRITE) && iCoeffValid;
  assign lastBeat = accept && (idx == (oNumOfCoeff - 1'b1));
  assign guardEnd = (guardCnt == GW'(GUARD_CYCLES - 1));

  assign oCoeffReady = (state == WRITE);

  // State register
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startOk) nextState = SETUP;
      SETUP:   nextState = iAbort ? IDLE : WRITE;
      WRITE: begin
        if (iAbort)        nextState = IDLE;
        else if (lastBeat) nextState = GUARD;
      end
      GUARD: begin
        if (iAbort)        nextState = IDLE;
        else if (guardEnd) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic: every output but oCoeffReady is registered, so this computes
  // the values they take after the coming edge.
  always_comb begin
    flagNxt   = (nextState == SETUP) || (nextState == WRITE) || (nextState == GUARD);
    // A beat taken in the abort cycle is consumed but never written.
    strobeNxt = accept && !iAbort;
    busyNxt   = (nextState != IDLE);
    doneNxt   = (nextState == DONE);
    errNxt    = startBad || abortHit;
  end

  // Output and datapath registers
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      oCoeffUpdateFlag <= 1'b0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oAddrRam         <= '0;
      oWrDtRam         <= '0;
      oNumOfCoeff      <= '0;
      oBusy            <= 1'b0;
      oDone            <= 1'b0;
      oErr             <= 1'b0;
      idx              <= '0;
      guardCnt         <= '0;
    end else begin
      oCoeffUpdateFlag <= flagNxt;
      oCsnRam          <= !strobeNxt;
      oWrnRam          <= !strobeNxt;
      oBusy            <= busyNxt;
      oDone            <= doneNxt;
      oErr             <= errNxt;

      if (startOk) begin
        oNumOfCoeff <= iNumOfCoeff;
        idx         <= '0;
      end else if (accept && !lastBeat) begin
        // Held on the last beat so the index never reaches N.
        idx <= idx + 1'b1;
      end

      // Address/data only move with a strobe; the SRAM ignores them otherwise.
      if (strobeNxt) begin
        oAddrRam <= idx;
        oWrDtRam <= iCoeffData;
      end

      if (state == GUARD) guardCnt <= guardCnt + 1'b1;
      else                guardCnt <= '0;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        iRsn;
  logic        iStart;
  logic        iAbort;
  logic [5:0]  iNumOfCoeff;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  always #5 clk = ~clk;

  fir_coeff_loader dut (
    .iClk12M          (clk),
    .iRsn             (iRsn),
    .iStart           (iStart),
    .iAbort           (iAbort),
    .iNumOfCoeff      (iNumOfCoeff),
    .iCoeffValid      (iCoeffValid),
    .iCoeffData       (iCoeffData),
    .oCoeffReady      (oCoeffReady),
    .oCoeffUpdateFlag (oCoeffUpdateFlag),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oAddrRam         (oAddrRam),
    .oWrDtRam         (oWrDtRam),
    .oNumOfCoeff      (oNumOfCoeff),
    .oBusy            (oBusy),
    .oDone            (oDone),
    .oErr             (oErr)
  );

  // Control view: {flag, csn, wrn, busy, done, err, ready}
  localparam logic [6:0] C_IDLE  = 7'b0110000;
  localparam logic [6:0] C_SETUP = 7'b1111000;
  localparam logic [6:0] C_WR    = 7'b1111001;
  localparam logic [6:0] C_WRS   = 7'b1001001;
  localparam logic [6:0] C_GDS   = 7'b1001000;
  localparam logic [6:0] C_GD    = 7'b1111000;
  localparam logic [6:0] C_DONE  = 7'b0111100;
  localparam logic [6:0] C_ERR   = 7'b0110010;

  typedef struct {
    logic        start;
    logic        abort;
    logic [5:0]  num;
    logic        vld;
    logic [15:0] dat;
    logic [6:0]  expCtl;
    logic [5:0]  expAddr;
    logic [15:0] expData;
    logic [5:0]  expNum;
  } vecT;

  vecT tbl[$];

  int nChecks = 0;
  int nErrs   = 0;

  // Monitor state, maintained by tick()
  logic [5:0]  stAddr[$];
  logic [15:0] stData[$];
  int          nDone;
  int          nErrPulse;
  int          wrnBad;
  logic [5:0]  maxAddr;
  int          sent;

  function automatic logic [6:0] ctl();
    return {oCoeffUpdateFlag, oCsnRam, oWrnRam, oBusy, oDone, oErr, oCoeffReady};
  endfunction

  function automatic void add(logic st, logic ab, logic [5:0] n, logic v, logic [15:0] d,
                              logic [6:0] c, logic [5:0] a, logic [15:0] wd, logic [5:0] en);
    vecT r;
    r.start = st; r.abort = ab; r.num = n; r.vld = v; r.dat = d;
    r.expCtl = c; r.expAddr = a; r.expData = wd; r.expNum = en;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clrMon();
    stAddr.delete();
    stData.delete();
    nDone = 0; nErrPulse = 0; wrnBad = 0; maxAddr = '0;
  endtask

  // Advance one cycle and observe the new outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (oCsnRam == 1'b0) begin
      stAddr.push_back(oAddrRam);
      stData.push_back(oWrDtRam);
    end
    if (oCsnRam !== oWrnRam) wrnBad++;
    if (oDone) nDone++;
    if (oErr) nErrPulse++;
    if (oAddrRam > maxAddr) maxAddr = oAddrRam;
  endtask

  task automatic startLoad(input logic [5:0] n);
    clrMon();
    sent = 0;
    iStart = 1'b1; iNumOfCoeff = n;
    tick();
    iStart = 1'b0;
  endtask

  // Stream base+k for beat k; stops at oDone, after stopAt accepts, or on a cycle bound.
  task automatic stream(input logic [15:0] base, input bit stall, input int stopAt);
    logic tog = 1'b0;
    logic accNow;
    for (int c = 0; c < 300; c++) begin
      if (nDone != 0 || sent == stopAt) break;
      tog = stall ? ~tog : 1'b1;
      iCoeffValid = tog;
      iCoeffData  = base + 16'(sent);
      accNow = tog && oCoeffReady;
      tick();
      if (accNow) sent++;
    end
    iCoeffValid = 1'b0;
  endtask

  task automatic chkStrobes(input string name, input int n, input logic [15:0] base);
    int bad = 0;
    chk({name, "_count"}, 64'(stAddr.size()), 64'(n));
    for (int i = 0; i < stAddr.size(); i++)
      if (stAddr[i] !== 6'(i) || stData[i] !== base + 16'(i)) bad++;
    chk({name, "_order"}, 64'(bad), 64'd0);
    chk({name, "_wrn"}, 64'(wrnBad), 64'd0);
  endtask

  initial begin
    iRsn = 1'b0; iStart = 1'b0; iAbort = 1'b0; iNumOfCoeff = '0;
    iCoeffValid = 1'b0; iCoeffData = '0;
    clrMon();
    sent = 0;

    // Nominal N=4 (valid offered in SETUP must not be taken; valid in GUARD ignored)
    add(1,0,6'd4, 0,16'h0000, C_IDLE , 6'd0,16'h0000,6'd0);
    add(0,0,6'd0, 1,16'h0001, C_SETUP, 6'd0,16'h0000,6'd4);
    add(0,0,6'd0, 1,16'h0001, C_WR   , 6'd0,16'h0000,6'd4);
    add(0,0,6'd0, 1,16'hFFFF, C_WRS  , 6'd0,16'h0001,6'd4);
    add(0,0,6'd0, 1,16'h7FFF, C_WRS  , 6'd1,16'hFFFF,6'd4);
    add(0,0,6'd0, 1,16'h8000, C_WRS  , 6'd2,16'h7FFF,6'd4);
    add(0,0,6'd0, 1,16'h1234, C_GDS  , 6'd3,16'h8000,6'd4);
    add(0,0,6'd0, 0,16'h0000, C_GD   , 6'd3,16'h8000,6'd4);
    add(0,0,6'd0, 0,16'h0000, C_DONE , 6'd3,16'h8000,6'd4);
    add(0,0,6'd0, 0,16'h0000, C_IDLE , 6'd3,16'h8000,6'd4);
    // Illegal counts 0 and 41; abort in IDLE is inert
    add(1,0,6'd0, 0,16'h0000, C_IDLE , 6'd3,16'h8000,6'd4);
    add(0,0,6'd0, 0,16'h0000, C_ERR  , 6'd3,16'h8000,6'd4);
    add(1,0,6'd41,0,16'h0000, C_IDLE , 6'd3,16'h8000,6'd4);
    add(0,0,6'd0, 0,16'h0000, C_ERR  , 6'd3,16'h8000,6'd4);
    add(0,1,6'd0, 0,16'h0000, C_IDLE , 6'd3,16'h8000,6'd4);
    add(0,0,6'd0, 0,16'h0000, C_IDLE , 6'd3,16'h8000,6'd4);
    // N=3 with a second start (N=5) during WRITE and another start+abort in DONE
    add(1,0,6'd3, 0,16'h0000, C_IDLE , 6'd3,16'h8000,6'd4);
    add(0,0,6'd0, 0,16'h0000, C_SETUP, 6'd3,16'h8000,6'd3);
    add(0,0,6'd0, 1,16'h0AAA, C_WR   , 6'd3,16'h8000,6'd3);
    add(1,0,6'd5, 0,16'h0000, C_WRS  , 6'd0,16'h0AAA,6'd3);
    add(0,0,6'd0, 1,16'h0BBB, C_WR   , 6'd0,16'h0AAA,6'd3);
    add(0,0,6'd0, 1,16'h0CCC, C_WRS  , 6'd1,16'h0BBB,6'd3);
    add(0,0,6'd0, 0,16'h0000, C_GDS  , 6'd2,16'h0CCC,6'd3);
    add(0,0,6'd0, 0,16'h0000, C_GD   , 6'd2,16'h0CCC,6'd3);
    add(1,1,6'd5, 0,16'h0000, C_DONE , 6'd2,16'h0CCC,6'd3);
    add(0,0,6'd0, 0,16'h0000, C_IDLE , 6'd2,16'h0CCC,6'd3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    iRsn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("row%0d", i), {29'd0, ctl(), oAddrRam, oWrDtRam, oNumOfCoeff},
          {29'd0, tbl[i].expCtl, tbl[i].expAddr, tbl[i].expData, tbl[i].expNum});
      iStart = tbl[i].start; iAbort = tbl[i].abort; iNumOfCoeff = tbl[i].num;
      iCoeffValid = tbl[i].vld; iCoeffData = tbl[i].dat;
      @(posedge clk);
      @(negedge clk);
    end
    iStart = 1'b0; iAbort = 1'b0; iCoeffValid = 1'b0;

    // Full depth N=40 with valid toggling every cycle
    startLoad(6'd40);
    stream(16'hC000, 1'b1, -1);
    chkStrobes("full", 40, 16'hC000);
    chk("full_maxaddr", 64'(maxAddr), 64'd39);
    chk("full_done", 64'(nDone), 64'd1);
    chk("full_err", 64'(nErrPulse), 64'd0);
    tick();
    chk("full_idle", 64'(ctl()), 64'(C_IDLE));

    // Abort after the 5th accept, with a 6th beat offered in the abort cycle
    startLoad(6'd10);
    stream(16'h5000, 1'b0, 5);
    iAbort = 1'b1; iCoeffValid = 1'b1; iCoeffData = 16'h5005;
    tick();
    iAbort = 1'b0; iCoeffValid = 1'b0;
    chk("abort_cycle", 64'(ctl()), 64'(C_ERR));
    repeat (5) tick();
    chkStrobes("abort", 5, 16'h5000);
    chk("abort_err", 64'(nErrPulse), 64'd1);
    chk("abort_nodone", 64'(nDone), 64'd0);

    startLoad(6'd2);
    stream(16'h0042, 1'b0, -1);
    chkStrobes("after_abort", 2, 16'h0042);
    chk("after_abort_done", 64'(nDone), 64'd1);
    chk("after_abort_err", 64'(nErrPulse), 64'd0);
    tick();

    // Reset for one cycle while in WRITE at idx 3
    startLoad(6'd8);
    stream(16'h3000, 1'b0, 3);
    iRsn = 1'b0; iCoeffValid = 1'b1;
    tick();
    iRsn = 1'b1; iCoeffValid = 1'b0;
    chk("rst_state", {29'd0, ctl(), oAddrRam, oWrDtRam, oNumOfCoeff},
        {29'd0, C_IDLE, 6'd0, 16'h0000, 6'd0});
    repeat (4) tick();
    chk("rst_noerr", 64'(nErrPulse), 64'd0);
    chk("rst_nodone", 64'(nDone), 64'd0);
    chk("rst_strobes", 64'(stAddr.size()), 64'd3);

    // Smallest legal load after reset
    startLoad(6'd1);
    stream(16'h8001, 1'b0, -1);
    chkStrobes("n1", 1, 16'h8001);
    chk("n1_done", 64'(nDone), 64'd1);

    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
